precomp_fetch_sched: RTL

- Sequencer for the fixed-base precomputation table ROM used by Ed25519 fixed-base scalar multiplication.
- On `start`, latches a 256-bit scalar and walks 32 rounds. Each round it forms the table address {round, scalar byte}, waits out the ROM's 1-cycle registered read, and hands the 255-bit entry to the point-add datapath over a valid/ready handshake.
- Constant-time: every round is fetched and presented regardless of digit value. Zero digits are never skipped.

---
 rtl/precomp_fetch_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/precomp_fetch_sched.sv
// Sequencer for the Ed25519 fixed-base precomputation ROM: walks all rounds of a
// latched scalar in constant time, fetching {round, digit} and presenting each entry.
module precomp_fetch_sched #(
    parameter int unsigned ROUNDS  = 32,
    parameter int unsigned ROUND_W = 5,
    parameter int unsigned DIGIT_W = 8,
    parameter int unsigned DATA_W  = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ROUNDS*DIGIT_W-1:0]   scalar,
    output logic                        busy,
    output logic [ROUND_W+DIGIT_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]           rom_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [ROUND_W-1:0]          out_round,
    output logic                        done
);

    localparam int unsigned SCALAR_W = ROUNDS * DIGIT_W;
    localparam int unsigned ADDR_W   = ROUND_W + DIGIT_W;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, PRESENT} state_t;

    state_t                state, state_d;
    logic [SCALAR_W-1:0]   scalar_q, scalar_d;
    logic [ROUND_W-1:0]    round, round_d, next_round;
    logic [DIGIT_W-1:0]    next_digit;
    logic                  busy_d, out_valid_d, done_d;
    logic [ADDR_W-1:0]     rom_addr_d;
    logic [DATA_W-1:0]     out_data_d;
    logic [ROUND_W-1:0]    out_round_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            scalar_q  <= '0;
            round     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            rom_addr  <= '0;
            out_data  <= '0;
            out_round <= '0;
        end else begin
            state     <= state_d;
            scalar_q  <= scalar_d;
            round     <= round_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            done      <= done_d;
            rom_addr  <= rom_addr_d;
            out_data  <= out_data_d;
            out_round <= out_round_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        scalar_d    = scalar_q;
        round_d     = round;
        busy_d      = busy;
        out_valid_d = out_valid;
        done_d      = done;
        rom_addr_d  = rom_addr;
        out_data_d  = out_data;
        out_round_d = out_round;
        next_round  = round + ROUND_W'(1);
        next_digit  = DIGIT_W'(scalar_q >> (DIGIT_W * next_round));

        case (state)
            IDLE: begin
                done_d = 1'b0;
                // A start coinciding with the done pulse must wait for a clean IDLE cycle
                if (start && !done) begin
                    scalar_d   = scalar;
                    round_d    = '0;
                    rom_addr_d = {ROUND_W'(0), scalar[DIGIT_W-1:0]};
                    busy_d     = 1'b1;
                    state_d    = WAIT1;
                end
            end
            WAIT1: begin
                state_d = WAIT2;
            end
            WAIT2: begin
                out_data_d  = rom_data;
                out_round_d = round;
                out_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (round == LAST_ROUND) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        round_d    = next_round;
                        rom_addr_d = {next_round, next_digit};
                        state_d    = WAIT1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
